ex_mdu_iter: RTL and testbench
==============================

// Module: ex_mdu_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage (RV M-extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Takes operands and rd from EX on a valid/ready handshake and computes one bit per cycle (shift-add / restoring divide).
//  Returns result plus rd toward the EX/MEM boundary; busy stalls the front end while an operation is in flight.
// PARAMETERS
//  XLEN     32  operand/result width (>=8, even)
//  RD_W     5   destination register index width
// PORTS
//  clk         in   1       clock, rising edge
//  arst_n      in   1       asynchronous active-low reset
//  flush       in   1       kill in-flight/held op (branch taken / trap)
//  req_valid   in   1       request present
//  req_ready   out  1       unit can accept a request
//  req_op      in   3       0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_opr_a   in   XLEN    rs1 operand
//  req_opr_b   in   XLEN    rs2 operand
//  req_rd      in   RD_W    destination register
//  res_valid   out  1       result present
//  res_ready   in   1       downstream accepts result
//  res_data    out  XLEN    result
//  res_rd      out  RD_W    destination register of result
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, arst_n=0): state=IDLE; res_valid=0, res_data=0, res_rd=0, busy=0; req_ready=1 after release.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: req_ready=1. Accept when req_valid&&req_ready&&!flush; latch op, rd, operand magnitudes, sign flags, count=XLEN.
//     Div special cases resolved at accept, go straight to DONE (latency 1):
//       b==0: DIV/DIVU q=all ones; REM/REMU r=a.
//       DIV/REM signed overflow a=MIN, b=-1: q=MIN, r=0.
//     Otherwise -> CALC.
//   CALC: one iteration per cycle, count decrements; on last iteration (count==1) -> DONE.
//     MUL*: 2*XLEN accumulator, add |b| shifted when multiplier LSB set; signs per op
//       (MULH both signed, MULHSU a signed b unsigned, MULHU/MUL unsigned magnitudes; MUL low half).
//     DIV*: restoring, remainder XLEN+1 bits; quotient sign = sa^sb, remainder sign = sa (signed ops only).
//     Sign fix-up (two's-complement negate) applied at CALC->DONE; result registered into res_data.
//   DONE: res_valid=1, res_data/res_rd stable until res_valid&&res_ready; then -> IDLE.
//     No new request accepted in DONE (req_ready=0): one op outstanding max.
//  Latency: normal op accepted cycle 0 -> res_valid cycle XLEN+1; special-case div -> cycle 1.
//  Throughput: with res_ready held 1, next request accepted the cycle after the handshake.
//  flush: any state -> IDLE next cycle, res_valid=0, result discarded; flush in IDLE blocks accept that cycle.
//  flush and res_ready in same DONE cycle: flush wins (no result counted downstream).
//  MUL result = low XLEN bits; MULH* = high XLEN bits. All arithmetic modulo 2^XLEN; no exceptions raised.
//  Operands changing after accept have no effect. Mid-op reset: async clear to reset values, no result emitted.
// TESTING
//  MUL a=7,b=-3 (0xFFFFFFFD) -> res 0xFFFFFFEB at cycle 33, res_rd echoed.
//  MULH a=0x80000000,b=0x80000000 -> 0x40000000; MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
//  DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 10/3 -> 1.
//  DIV x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; all res_valid at cycle 1.
//  res_ready=0 for 5 cycles in DONE -> res_valid/res_data/res_rd held, req_ready=0; accept resumes after handshake.
//  flush at CALC cycle 10 -> IDLE next cycle, no res_valid; arst_n pulse mid-CALC -> all outputs 0, busy=0.

Source files
------------

// File: rtl/ex_mdu_iter.sv
// ex_mdu_iter: iterative RV M-extension multiply/divide unit, one bit per cycle.
// Shift-add multiply and restoring divide share the hi/lo working registers.
module ex_mdu_iter #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_opr_a,
   input  logic [XLEN-1:0] req_opr_b,
   input  logic [RD_W-1:0] req_rd,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] res_data,
   output logic [RD_W-1:0] res_rd,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
   state_t state, state_nx;
   logic [2:0] op;
   logic [XLEN-1:0] hi, lo, b_mag;
   logic neg_q, neg_r;
   logic [CW-1:0] count;
   logic sa, sb, div0, ovf, special, accept;
   logic [XLEN-1:0] a_mag_in, b_mag_in, spec_res, hi_nx, lo_nx, quo, rmd, fin;
   logic [XLEN:0] mul_sum, div_sh, div_df;
   logic [2*XLEN-1:0] prod;
   always_comb begin
      sa       = (req_op == 3'd1 || req_op == 3'd2 || req_op == 3'd4 || req_op == 3'd6) && req_opr_a[XLEN-1];
      sb       = (req_op == 3'd1 || req_op == 3'd4 || req_op == 3'd6) && req_opr_b[XLEN-1];
      a_mag_in = sa ? -req_opr_a : req_opr_a;
      b_mag_in = sb ? -req_opr_b : req_opr_b;
      div0     = req_op[2] && req_opr_b == '0;
      ovf      = !req_op[0] && req_op[2] && req_opr_a == MIN && req_opr_b == '1;
      special  = div0 || ovf;
      // overflow quotient equals the dividend (MIN); b==0 remainder equals the dividend
      spec_res = div0 ? (req_op[1] ? req_opr_a : '1) : (req_op[1] ? '0 : req_opr_a);
      accept   = state == IDLE && req_valid && !flush;
   end
   always_comb begin
      mul_sum = lo[0] ? {1'b0, hi} + {1'b0, b_mag} : {1'b0, hi};
      div_sh  = {hi, lo[XLEN-1]};
      div_df  = div_sh - {1'b0, b_mag};
      hi_nx   = op[2] ? (div_df[XLEN] ? div_sh[XLEN-1:0] : div_df[XLEN-1:0]) : mul_sum[XLEN:1];
      lo_nx   = op[2] ? {lo[XLEN-2:0], ~div_df[XLEN]} : {mul_sum[0], lo[XLEN-1:1]};
      prod    = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
      quo     = neg_q ? -lo_nx : lo_nx;
      rmd     = neg_r ? -hi_nx : hi_nx;
      fin     = op[2] ? (op[1] ? rmd : quo) : (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end
   always_ff @(posedge clk or negedge arst_n)
      if (!arst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else if (state == IDLE && req_valid) state_nx = special ? DONE : CALC;
      else if (state == CALC && count == CW'(1)) state_nx = DONE;
      else if (state == DONE && res_ready) state_nx = IDLE;
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         op       <= '0;
         hi       <= '0;
         lo       <= '0;
         b_mag    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         count    <= '0;
         res_data <= '0;
         res_rd   <= '0;
      end else if (accept) begin
         op       <= req_op;
         hi       <= '0;
         lo       <= a_mag_in;
         b_mag    <= b_mag_in;
         neg_q    <= sa ^ sb;
         neg_r    <= sa;
         count    <= CW'(XLEN);
         res_rd   <= req_rd;
         if (special) res_data <= spec_res;
      end else if (state == CALC && !flush) begin
         hi    <= hi_nx;
         lo    <= lo_nx;
         count <= count - CW'(1);
         if (count == CW'(1)) res_data <= fin;
      end
   end
   assign req_ready = state == IDLE;
   assign res_valid = state == DONE;
   assign busy      = state != IDLE;
endmodule

// File: tb/tb_ex_mdu_iter.sv
// tb_ex_mdu_iter: directed checks of ex_mdu_iter results, latency, hold, flush and reset.
module tb_ex_mdu_iter;
   logic clk = 1'b0, arst_n = 1'b0, flush = 1'b0, req_valid = 1'b0, res_ready = 1'b1;
   logic req_ready, res_valid, busy;
   logic [2:0] req_op = '0;
   logic [31:0] req_opr_a = '0, req_opr_b = '0, res_data;
   logic [4:0] req_rd = '0, res_rd;
   int total = 0, bad = 0;

   ex_mdu_iter #(.XLEN(32), .RD_W(5)) dut (
      .clk(clk), .arst_n(arst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_opr_a(req_opr_a), .req_opr_b(req_opr_b), .req_rd(req_rd),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      req_op = op; req_opr_a = a; req_opr_b = b; req_rd = rd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_opr_a = 32'h5A5A_A5A5; req_opr_b = 32'h1234_5678; req_op = 3'd0; req_rd = 5'd0;
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input int lat);
      int n;
      start(op, a, b, rd);
      n = 1;
      while (!res_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_data"}, res_data, exp);
      chk({tag, "_rd"}, {27'd0, res_rd}, {27'd0, rd});
      @(posedge clk); #1;
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int n;
      logic seen;
      #12;
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_data", res_data, 32'd0);
      chk("rst_rd", {27'd0, res_rd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); arst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);

      run("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
      run("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 33);
      run("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 33);
      run("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
      run("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 33);
      run("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 33);
      run("divu",   3'd5, 32'hFFFF_FFFF,  32'd2,         5'd9,  32'h7FFF_FFFF, 33);
      run("remu",   3'd7, 32'd10,         32'd3,         5'd10, 32'd1,         33);
      run("div0",   3'd4, 32'd1234,       32'd0,         5'd11, 32'hFFFF_FFFF, 1);
      run("rem0",   3'd6, 32'd5,          32'd0,         5'd12, 32'd5,         1);
      run("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
      run("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1);

      res_ready = 1'b0;
      start(3'd7, 32'd100, 32'd7, 5'd21);
      n = 1;
      while (!res_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold_lat", n, 33);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'd0, res_valid}, 32'd1);
         chk("hold_data", res_data, 32'd2);
         chk("hold_rd", {27'd0, res_rd}, 32'd21);
         chk("hold_ready", {31'd0, req_ready}, 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release", {31'd0, res_valid}, 32'd0);
      run("after_hold", 3'd5, 32'd100, 32'd7, 5'd22, 32'd14, 33);

      flush = 1'b1; req_valid = 1'b1; req_op = 3'd4; req_opr_b = 32'd0;
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      chk("flush_idle_busy", {31'd0, busy}, 32'd0);

      start(3'd0, 32'd9, 32'd9, 5'd15);
      for (int i = 1; i < 10; i++) begin
         @(posedge clk); #1;
      end
      chk("flush_calc_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen |= res_valid;
      end
      chk("flush_no_result", {31'd0, seen}, 32'd0);

      start(3'd1, 32'd1000, 32'd3, 5'd17);
      repeat (5) @(posedge clk);
      #3 arst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, res_valid}, 32'd0);
      chk("arst_data", res_data, 32'd0);
      chk("arst_rd", {27'd0, res_rd}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); arst_n = 1'b1;
      run("post_rst", 3'd0, 32'd6, 32'd7, 5'd31, 32'd42, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
